// File: rtl/rc_pkg.sv
// Shared raised-cosine constants and the output rounding/saturation helper.
// The transmit shaper imports the same package, so both ends use one
// coefficient set and one rounding rule.
package rc_pkg;

    localparam int SPS    = 4;                        // samples per symbol
    localparam int NTAPS  = 9;                        // FIR length
    localparam int DATA_W = 16;                       // sample width
    localparam int COEF_W = 16;                       // Q1.15 coefficient width
    localparam int ACC_W  = 36;                       // full-precision accumulator
    localparam int PH_W   = $clog2(SPS);              // sampling phase / counter width
    localparam int PROD_W = DATA_W + COEF_W;          // single-product width

    // Symmetric about the centre tap; zero end taps are kept so the table
    // lines up with the transmit side.
    localparam logic signed [COEF_W-1:0] RC_COEF [NTAPS] = '{
        16'sd0,     16'sd2500, 16'sd9500, 16'sd14000, 16'sd16384,
        16'sd14000, 16'sd9500, 16'sd2500, 16'sd0
    };

    // Half an output LSB for round-half-up before dropping the Q15 fraction.
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(longint'(1) << (COEF_W - 2));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    // Round half up, arithmetic shift out the Q15 fraction, clamp to int16.
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] scaled;
        scaled = (acc + RND_HALF) >>> (COEF_W - 1);
        if (scaled > SAT_MAX)
            sat16 = SAT_MAX[DATA_W-1:0];
        else if (scaled < SAT_MIN)
            sat16 = SAT_MIN[DATA_W-1:0];
        else
            sat16 = scaled[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/rc_fir_core.sv
// Matched raised-cosine FIR: delay line, registered products, then a
// full-precision sum that is rounded and saturated into the output register.
// Every stage advances only when en_i is high.
module rc_fir_core
    import rc_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] x_i,
    output logic signed [DATA_W-1:0] y_d_o,
    output logic signed [DATA_W-1:0] y_o
);

    logic signed [DATA_W-1:0] dly_p0_q  [NTAPS];
    logic signed [PROD_W-1:0] prod_p1_q [NTAPS];
    logic signed [ACC_W-1:0]  sum_p2_d;
    logic signed [DATA_W-1:0] y_p2_q;

    // Stage 0: shift the new sample in; tap 0 holds the newest sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NTAPS; i++) dly_p0_q[i] <= '0;
        end else if (en_i) begin
            dly_p0_q[0] <= x_i;
            for (int i = 1; i < NTAPS; i++) dly_p0_q[i] <= dly_p0_q[i-1];
        end
    end

    // Stage 1: one registered product per tap (zero taps fold away).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NTAPS; i++) prod_p1_q[i] <= '0;
        end else if (en_i) begin
            for (int i = 0; i < NTAPS; i++) prod_p1_q[i] <= dly_p0_q[i] * RC_COEF[i];
        end
    end

    // Stage 2: full-precision sum of the sign-extended products.
    always_comb begin
        sum_p2_d = '0;
        for (int i = 0; i < NTAPS; i++) sum_p2_d = sum_p2_d + ACC_W'(prod_p1_q[i]);
    end

    assign y_d_o = sat16(sum_p2_d);

    // Stage 2 register: rounded and saturated filter output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            y_p2_q <= '0;
        else if (en_i)
            y_p2_q <= y_d_o;
    end

    assign y_o = y_p2_q;

endmodule

// File: rtl/raised_cosine_rx.sv
// Raised-cosine receiver: matched FIR at the full sample rate, followed by
// decimation at a latched sampling phase and a sign slicer. Each input
// sample is tagged at entry with whether it is the symbol sample of its
// window; the tag rides alongside the FIR pipeline to the decimator.
module raised_cosine_rx
    import rc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic signed [DATA_W-1:0] In1,
    input  logic        [PH_W-1:0]   phase_sel,
    output logic                     ce_out,
    output logic signed [DATA_W-1:0] Out1,
    output logic                     sym_valid,
    output logic signed [DATA_W-1:0] sym_out,
    output logic                     sym_bit
);

    logic [PH_W-1:0]          cnt_q;
    logic [PH_W-1:0]          phase_q;
    logic [PH_W-1:0]          phase_eff;
    logic                     rel_q;
    logic                     hit_d;
    logic                     vld_p0_q;
    logic                     vld_p1_q;
    logic                     sym_vld_q;
    logic                     sym_bit_q;
    logic signed [DATA_W-1:0] y_d;
    logic signed [DATA_W-1:0] y_q;
    logic signed [DATA_W-1:0] sym_out_q;

    rc_fir_core u_fir (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (clk_enable),
        .x_i    (In1),
        .y_d_o  (y_d),
        .y_o    (y_q)
    );

    // Right after reset release the phase input is used directly, so the
    // first window already sees the value present at release.
    assign phase_eff = rel_q ? phase_sel : phase_q;
    assign hit_d     = (cnt_q == phase_eff);

    // Sample counter and phase latch; phase only changes at window boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
            rel_q   <= 1'b1;
        end else begin
            rel_q <= 1'b0;
            if (rel_q || (clk_enable && cnt_q == PH_W'(SPS - 1)))
                phase_q <= phase_sel;
            if (clk_enable)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Stage 0 / stage 1: symbol tag travelling with its sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
        end else if (clk_enable) begin
            vld_p0_q <= hit_d;
            vld_p1_q <= vld_p0_q;
        end
    end

    // Stage 2: decimator and slicer, written together with Out1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_vld_q <= 1'b0;
            sym_out_q <= '0;
            sym_bit_q <= 1'b1;
        end else if (clk_enable) begin
            sym_vld_q <= vld_p1_q;
            if (vld_p1_q) begin
                sym_out_q <= y_d;
                sym_bit_q <= ~y_d[DATA_W-1];
            end
        end
    end

    assign ce_out    = clk_enable;
    assign Out1      = y_q;
    assign sym_out   = sym_out_q;
    assign sym_bit   = sym_bit_q;
    // The strobe is held until the next enabled cycle so it never shows
    // while the sample stream is paused.
    assign sym_valid = sym_vld_q & clk_enable;

endmodule

// File: doc/raised_cosine_rx.md
Name: raised_cosine_rx

Overview:
- Receive-side counterpart of the raised-cosine transmit pulse shaper. It applies the matched raised-cosine FIR to the int16 sample stream and rounds and saturates the result to int16.
- It then decimates by SPS at a selectable sampling phase and slices each kept sample to a hard bit.
- It sits between the channel/ADC sample stream and the symbol demapper. It uses the same clk / reset / clk_enable / ce_out handshake as the transmit filter.

Parameters:
- SPS, 4, samples per symbol; decimation factor; power of two.
- NTAPS, 9, FIR length; odd; coefficients symmetric about tap (NTAPS-1)/2.
- DATA_W, 16, input and output sample width, signed two's complement.
- COEF_W, 16, coefficient width, signed Q1.15.
- ACC_W, 36, accumulator width = DATA_W + COEF_W + ceil(log2 NTAPS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- clk_enable  in  1  sample strobe; one input sample per cycle while high.
- In1  in  16  signed int16 received sample.
- phase_sel  in  log2(SPS)  decimation sampling phase, 0..SPS-1.
- ce_out  out  1  clock-enable pass-through, equal to clk_enable (combinational).
- Out1  out  16  signed int16 matched-filter output at the full sample rate.
- sym_valid  out  1  one-cycle strobe marking a decimated symbol sample.
- sym_out  out  16  signed int16 decimated sample, held between strobes.
- sym_bit  out  1  hard decision: 1 if sym_out >= 0, else 0.

Behaviour:
- Reset (reset = 0, asynchronous) clears the following, regardless of clk_enable:
  - delay line, product and sum registers;
  - sample counter and latched phase;
  - Out1 = 0, sym_out = 0, sym_valid = 0, sym_bit = 1.
- Reset mid-stream discards all in-flight samples. The first enabled sample after reset release is index k = 0.
- Coefficients (Q1.15): {0, 2500, 9500, 14000, 16384, 14000, 9500, 2500, 0}.
- Filter: y[k] = sat16((sum over i of c[i]·x[k−i] + 2^14) >>> 15).
  - Accumulation is full precision in ACC_W bits.
  - The shift is arithmetic; rounding is round-half-up.
  - Results above 32767 clamp to 32767; below −32768 clamp to −32768.
- Pipeline, advancing only on cycles with clk_enable = 1:
  - Stage 0: shift In1 into the delay line.
  - Stage 1: register the NTAPS products. Zero taps may be pruned but stay bit-exact.
  - Stage 2: sum, round and saturate into Out1.
- Latency: y[k] appears on Out1 two enabled cycles after x[k] is sampled.
- clk_enable = 0: every register holds, Out1 and sym_out hold, sym_valid = 0.
- Sample counter:
  - 0..SPS−1, incremented on each enabled sample and wrapping SPS−1 → 0.
  - It travels down the pipeline with its sample.
- Decimation: when y[k] is written to Out1 and (k mod SPS) == latched phase:
  - sym_out <= y[k], sym_bit <= ~y[k][15], sym_valid = 1 for that cycle only;
  - otherwise sym_valid = 0.
- phase_sel latching:
  - Latched at reset release, and afterwards only when the input counter wraps to 0.
  - A change mid-symbol therefore takes effect from the next symbol boundary.
  - No symbol is ever emitted twice or skipped within one SPS window.
- Out-of-range phase_sel cannot occur when SPS is a power of two.

Decomposition:
- Package rc_pkg holds the following, shared with the transmit shaper so both ends stay matched:
  - SPS, NTAPS, DATA_W, COEF_W, ACC_W;
  - the RC_COEF constant array;
  - the sat16 rounding/saturation function.
- One natural sub-module: rc_fir_core, covering the delay line, products, sum and saturation, with a clk_enable-qualified pipeline. The top level adds the counter, phase latch, decimator and slicer.

Test Plan:
- Impulse, phase_sel = 0, clk_enable held high:
  - stimulus: In1 = 16384 at k = 0, then zeros;
  - Out1 sequence from the third cycle: 0, 1250, 4750, 7000, 8192, 7000, 4750, 1250, 0;
  - sym_valid at k = 0, 4, 8 with sym_out 0, 8192, 0.
- Same impulse with phase_sel = 1 -> sym_valid at k = 1, 5 with sym_out 1250 then 7000; sym_bit = 1 on both.
- Saturation:
  - constant In1 = 32767 -> steady-state Out1 = 32767, sym_bit = 1;
  - constant In1 = −32768 -> Out1 = −32768, sym_bit = 0.
- Alternating In1 = +32767 (even k) / −32768 (odd k) -> Out1 alternates 2383 and −2385 once the delay line is full; no saturation.
- Gaps in clk_enable: insert 3 low cycles between every sample of the impulse test.
  - Out1 and sym_* values must match the gap-free run exactly.
  - sym_valid must never be high on a clk_enable = 0 cycle.
- Reset and phase change:
  - assert reset for 1 cycle mid-impulse -> all outputs 0 and sym_bit = 1 immediately; the next sample is treated as k = 0;
  - change phase_sel at k = 2 -> the new phase applies only from k = 4.
